ocl_fifo_bridge: RTL and testbench
==================================

# ocl_fifo_bridge

Multi-channel register-to-stream bridge between the OCL AXI-Lite register decode and the accelerator cores in the CL. Each of `NUM_CH` channels has a host-to-accelerator TX FIFO and an accelerator-to-host RX FIFO. A per-channel data/status/control register window is decoded from `BASE_ADDR`. Compared with the single-channel design, it adds:
- blocking reads with timeout
- error responses
- per-channel status and flush
- parametrised data width and depth

## Interface
Parameters:
- `NUM_CH`, 2: number of channels (1–8).
- `DATA_W`, 32: FIFO data width (8–32). Host writes are truncated to `DATA_W`; reads are zero-extended to 32.
- `DEPTH`, 16: entries per FIFO. Power of two, 2–128.
- `BASE_ADDR`, 32'h0000_0600: channel 0 window. Channel n is at `BASE_ADDR + n*0x10`.
- `RD_TIMEOUT`, 256: cycles a data read waits on an empty RX FIFO.

Ports:
- `clk_main_a0` in 1: single clock.
- `rst_main_n_sync` in 1: reset, **asynchronous, active-low**.
- `wr_valid` in 1: one-cycle write strobe; qualifies `wr_addr` and `wdata`.
- `wr_addr` in 32: write address.
- `wdata` in 32: write data.
- `wr_err` out 1: one-cycle pulse, the cycle after a rejected write.
- `arvalid` in 1: read request.
- `araddr` in 32: read address.
- `arready` out 1: high only in IDLE.
- `rvalid` out 1: read response valid.
- `rdata` out 32: read response data.
- `rresp` out 2: read response code.
- `rready` in 1: host accepts response.
- `acc_tx_valid` out NUM_CH: TX FIFO not empty.
- `acc_tx_data` out NUM_CH*DATA_W: TX FIFO head word.
- `acc_tx_ready` in NUM_CH: accelerator pops TX.
- `acc_rx_valid` in NUM_CH: accelerator pushes RX.
- `acc_rx_data` in NUM_CH*DATA_W: RX push data.
- `acc_rx_ready` out NUM_CH: RX FIFO not full.

## Operation
Register window per channel, offset from the channel base:
- **+0x0 DATA.** A write pushes the TX FIFO. A read pops the RX FIFO.
- **+0x4 STATUS** (read-only):
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty
  - [15:8] tx_count, [23:16] rx_count
  - [31:24] zero
- **+0x8 CTRL** (write-only, self-clearing):
  - bit0 flushes TX, bit1 flushes RX.
  - Reads return 0.

Write rules:
- A DATA write to a full TX FIFO is dropped and pulses `wr_err`.
- An unmapped write or a STATUS write is ignored and pulses `wr_err`.
- Writes are processed independently of the read FSM.

Read FSM states: IDLE, WAIT_DATA, POP, CAPTURE, RESP.
- **IDLE:** `arready`=1. On `arvalid`:
  - DATA read with RX non-empty → POP.
  - DATA read with RX empty → WAIT_DATA; timeout counter cleared.
  - STATUS or CTRL read → RESP, `rresp`=00.
  - Unmapped read → RESP, `rdata`=0xAAAA_AAAA, `rresp`=11 (DECERR).
- **WAIT_DATA:**
  - RX becomes non-empty → POP.
  - Counter reaches `RD_TIMEOUT`-1 → RESP, `rdata`=0xDEAD_0000, `rresp`=10 (SLVERR).
- **POP:** one-cycle FIFO read strobe → CAPTURE.
- **CAPTURE:** registers FIFO `dout` into `rdata`, `rresp`=00 → RESP.
- **RESP:** `rvalid`=1, `rdata`/`rresp` held stable until `rvalid & rready`, then → IDLE.

FIFO rules:
- Push when full is ignored; pop when empty is ignored.
- Simultaneous push and pop both happen; count is unchanged.
- Flush empties the FIFO in one cycle and wins over a same-cycle push or pop.
- Pointers wrap modulo `DEPTH`. Count width is clog2(DEPTH)+1.
- A flush of RX while in WAIT_DATA keeps waiting. An RX flush cannot hit POP/CAPTURE because the entry is already committed.

Reset (asynchronous assert, all registers):
- `rvalid`=0, `rdata`=0, `rresp`=0, `wr_err`=0.
- FSM in IDLE, all FIFOs empty.
- Hence `arready`=1, `acc_tx_valid`=0, `acc_rx_ready`=all ones.
- Reset mid-transaction abandons the read; no response is issued.

## Timing
- Read, non-empty RX: `arvalid` accepted at cycle T; POP at T+1; CAPTURE at T+2; `rvalid` high at T+3.
- STATUS, CTRL and unmapped reads: `rvalid` at T+1. STATUS reflects state as of cycle T.
- Timeout read: `rvalid` at T+1+`RD_TIMEOUT`.
- Write path:
  - Push visible on `acc_tx_valid` one cycle after `wr_valid`.
  - `wr_err` one cycle after `wr_valid`.
- Accelerator pushes/pops are valid&ready handshakes, one word per cycle per channel.

## Structure
- **Package `ocl_fifo_pkg`:**
  - register offsets (DATA/STATUS/CTRL)
  - response codes OKAY/SLVERR/DECERR
  - constants 0xDEAD_0000 and 0xAAAA_AAAA
  - read-FSM state enum
- **Sub-module `sync_fifo`:** parametrised by DATA_W and DEPTH; registered `dout`; flush input; outputs full, empty and count. Instantiated 2×NUM_CH times via generate.

## Test plan
1. **TX push/pop:** write 0x1234_5678 to ch1 DATA → `acc_tx_valid[1]`=1 next cycle, `acc_tx_data` ch1 = 0x1234_5678; after pop, STATUS tx_count=0.
2. **Blocking read:** read ch0 DATA with RX empty; push 0xCAFE_0001 on ch0 after 10 cycles → `rvalid` with 0xCAFE_0001, `rresp`=00, no timeout.
3. **Timeout:** read ch0 DATA, no push for 256 cycles → `rdata`=0xDEAD_0000, `rresp`=10 at T+257.
4. **Full/wrap:** write 17 words to ch0 (DEPTH=16) → 17th pulses `wr_err`. Drain 16, refill 16 → data order preserved across pointer wrap.
5. **Flush:** fill RX ch1 with 5 words, write CTRL=0x2 → STATUS rx_empty=1, rx_count=0. Same-cycle accelerator push is dropped.
6. **Response stall and reset:**
   - Hold `rready`=0 for 20 cycles → `rdata` stable; unmapped read returns 0xAAAA_AAAA with `rresp`=11.
   - Assert reset during WAIT_DATA → `rvalid`=0 immediately and FSM returns to IDLE.

Source files
------------

// File: rtl/ocl_fifo_pkg.sv
// Shared constants, read-FSM states and the register-window decoder for the
// OCL multi-channel FIFO bridge.
package ocl_fifo_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] RD_TMO_DATA = 32'hDEAD_0000;
  localparam logic [31:0] RD_DEC_DATA = 32'hAAAA_AAAA;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_DATA, ST_POP, ST_CAPTURE, ST_RESP
  } rd_state_e;

  typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_CTRL, REG_NONE} reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] ch;
  } reg_dec_t;

  // Anything outside the channel windows or off the three word offsets is unmapped.
  function automatic reg_dec_t reg_decode(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int          num_ch);
    logic [31:0] off;
    reg_dec_t    d;
    off   = addr - base;
    d.ch  = off[6:4];
    d.sel = REG_NONE;
    if (addr >= base && off < 32'(num_ch * 16)) begin
      case (off[3:0])
        OFF_DATA:   d.sel = REG_DATA;
        OFF_STATUS: d.sel = REG_STATUS;
        OFF_CTRL:   d.sel = REG_CTRL;
        default:    d.sel = REG_NONE;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pop data, a show-ahead head word and a
// one-cycle flush that overrides push/pop.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [DATA_W-1:0]      din,
  input  logic                   pop,
  output logic [DATA_W-1:0]      dout,
  output logic [DATA_W-1:0]      head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = dout_q;
  assign head    = mem[rptr_q];
  assign count   = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // A committed pop still delivers its word even if a flush lands with it.
    dout_d  = do_pop ? mem[rptr_q] : dout_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr_q] <= din;
  end

endmodule

// File: rtl/ocl_fifo_bridge.sv
// Multi-channel register-to-stream bridge: per-channel TX/RX FIFOs behind a
// DATA/STATUS/CTRL register window, with a blocking, timed-out read path.
module ocl_fifo_bridge
  import ocl_fifo_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          DATA_W     = 32,
  parameter int          DEPTH      = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0600,
  parameter int          RD_TIMEOUT = 256
) (
  input  logic                     clk_main_a0,
  input  logic                     rst_main_n_sync,
  input  logic                     wr_valid,
  input  logic [31:0]              wr_addr,
  input  logic [31:0]              wdata,
  output logic                     wr_err,
  input  logic                     arvalid,
  input  logic [31:0]              araddr,
  output logic                     arready,
  output logic                     rvalid,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  input  logic                     rready,
  output logic [NUM_CH-1:0]        acc_tx_valid,
  output logic [NUM_CH*DATA_W-1:0] acc_tx_data,
  input  logic [NUM_CH-1:0]        acc_tx_ready,
  input  logic [NUM_CH-1:0]        acc_rx_valid,
  input  logic [NUM_CH*DATA_W-1:0] acc_rx_data,
  output logic [NUM_CH-1:0]        acc_rx_ready
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW  = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;

  logic [NUM_CH-1:0]             tx_push, tx_flush, rx_flush, rx_pop;
  logic [NUM_CH-1:0]             tx_full, tx_empty, rx_full, rx_empty;
  logic [NUM_CH-1:0][CW-1:0]     tx_count, rx_count;
  logic [NUM_CH-1:0][DATA_W-1:0] tx_head, rx_dout, rx_din;
  logic [NUM_CH-1:0][DATA_W-1:0] tx_dout_unused, rx_head_unused;
  logic                          tie_unused;

  assign rx_din       = acc_rx_data;
  assign acc_tx_data  = tx_head;
  assign acc_tx_valid = ~tx_empty;
  assign acc_rx_ready = ~rx_full;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
      .clk(clk_main_a0), .rst_n(rst_main_n_sync), .flush(tx_flush[g]),
      .push(tx_push[g]), .din(wdata[DATA_W-1:0]), .pop(acc_tx_ready[g]),
      .dout(tx_dout_unused[g]), .head(tx_head[g]), .full(tx_full[g]),
      .empty(tx_empty[g]), .count(tx_count[g]));
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
      .clk(clk_main_a0), .rst_n(rst_main_n_sync), .flush(rx_flush[g]),
      .push(acc_rx_valid[g]), .din(rx_din[g]), .pop(rx_pop[g]),
      .dout(rx_dout[g]), .head(rx_head_unused[g]), .full(rx_full[g]),
      .empty(rx_empty[g]), .count(rx_count[g]));
  end

  // ---------------- write path ----------------
  reg_dec_t       wr_dec;
  logic [CHW-1:0] wch;
  logic           wr_err_q, wr_err_d;

  always_comb begin
    wr_dec   = reg_decode(wr_addr, BASE_ADDR, NUM_CH);
    wch      = wr_dec.ch[CHW-1:0];
    tx_push  = '0;
    tx_flush = '0;
    rx_flush = '0;
    wr_err_d = 1'b0;
    if (wr_valid) begin
      case (wr_dec.sel)
        REG_DATA: begin
          if (tx_full[wch]) wr_err_d = 1'b1;
          else              tx_push[wch] = 1'b1;
        end
        REG_CTRL: begin
          tx_flush[wch] = wdata[0];
          rx_flush[wch] = wdata[1];
        end
        default: wr_err_d = 1'b1;
      endcase
    end
  end

  assign wr_err = wr_err_q;

  // ---------------- read FSM ----------------
  reg_dec_t       rd_dec;
  logic [CHW-1:0] ach;
  logic [31:0]    status;
  rd_state_e      state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           rvalid_q, rvalid_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [1:0]     rresp_q, rresp_d;

  always_comb begin
    rd_dec   = reg_decode(araddr, BASE_ADDR, NUM_CH);
    ach      = rd_dec.ch[CHW-1:0];
    status   = {8'h00, 8'(rx_count[ach]), 8'(tx_count[ach]), 4'h0,
                rx_empty[ach], rx_full[ach], tx_empty[ach], tx_full[ach]};
    state_d  = state_q;
    ch_d     = ch_q;
    tmo_d    = tmo_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rx_pop   = '0;
    case (state_q)
      ST_IDLE: if (arvalid) begin
        ch_d = ach;
        case (rd_dec.sel)
          REG_DATA: begin
            tmo_d   = '0;
            state_d = rx_empty[ach] ? ST_WAIT_DATA : ST_POP;
          end
          REG_STATUS: begin
            rdata_d = status;  rresp_d = RESP_OKAY;
            rvalid_d = 1'b1;   state_d = ST_RESP;
          end
          REG_CTRL: begin
            rdata_d = '0;      rresp_d = RESP_OKAY;
            rvalid_d = 1'b1;   state_d = ST_RESP;
          end
          default: begin
            rdata_d = RD_DEC_DATA;  rresp_d = RESP_DECERR;
            rvalid_d = 1'b1;        state_d = ST_RESP;
          end
        endcase
      end
      ST_WAIT_DATA: begin
        // Data arriving on the last waiting cycle still beats the timeout.
        if (!rx_empty[ch_q]) begin
          state_d = ST_POP;
        end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
          rdata_d = RD_TMO_DATA;  rresp_d = RESP_SLVERR;
          rvalid_d = 1'b1;        state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_POP: begin
        rx_pop[ch_q] = 1'b1;
        state_d      = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        rdata_d = 32'(rx_dout[ch_q]);  rresp_d = RESP_OKAY;
        rvalid_d = 1'b1;               state_d = ST_RESP;
      end
      ST_RESP: if (rready) begin
        rvalid_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
    if (!rst_main_n_sync) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      tmo_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      tmo_q    <= tmo_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign arready = (state_q == ST_IDLE);
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  assign tie_unused = ^{wdata, wr_dec.ch, rd_dec.ch, tx_dout_unused, rx_head_unused};

endmodule

// File: tb/tb_ocl_fifo_bridge.sv
// Bench for ocl_fifo_bridge: table of register accesses, directed corner
// sequences and a randomized phase against a queue-based model.
module tb_ocl_fifo_bridge;
  localparam int          NCH  = 2;
  localparam int          DW   = 32;
  localparam int          DEP  = 16;
  localparam int          TMO  = 256;
  localparam logic [31:0] BASE = 32'h0000_0600;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_valid = 1'b0;
  logic [31:0]       wr_addr = '0, wdata = '0;
  logic              wr_err;
  logic              arvalid = 1'b0;
  logic [31:0]       araddr = '0;
  logic              arready, rvalid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rready = 1'b1;
  logic [NCH-1:0]    acc_tx_valid, acc_tx_ready = '0;
  logic [NCH*DW-1:0] acc_tx_data;
  logic [NCH-1:0]    acc_rx_valid = '0, acc_rx_ready;
  logic [NCH*DW-1:0] acc_rx_data = '0;

  ocl_fifo_bridge #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .BASE_ADDR(BASE),
                    .RD_TIMEOUT(TMO)) dut (
    .clk_main_a0(clk), .rst_main_n_sync(rst_n),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wdata(wdata), .wr_err(wr_err),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .acc_tx_valid(acc_tx_valid), .acc_tx_data(acc_tx_data), .acc_tx_ready(acc_tx_ready),
    .acc_rx_valid(acc_rx_valid), .acc_rx_data(acc_rx_data), .acc_rx_ready(acc_rx_ready));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] tx_m [NCH][$];
  logic [31:0] rx_m [NCH][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 0 DATA, 1 STATUS, 2 CTRL, 3 unmapped
  function automatic int bdec(input logic [31:0] a, output int c);
    int off;
    c = 0;
    if (a < BASE || a >= BASE + NCH * 16) return 3;
    off = int'(a - BASE);
    c   = off / 16;
    case (off % 16)
      0: return 0;
      4: return 1;
      8: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] m_status(input int c);
    int t, r;
    t = tx_m[c].size();
    r = rx_m[c].size();
    return {8'h00, 8'(r), 8'(t), 4'h0, r == 0, r == DEP, t == 0, t == DEP};
  endfunction

  // One clock of host write / accelerator traffic, checked and mirrored in the model.
  task automatic cyc(input bit we, input logic [31:0] wa, input logic [31:0] wd,
                     input logic [NCH-1:0] txr, input logic [NCH-1:0] rxv,
                     input logic [NCH*DW-1:0] rxd);
    int k, c;
    bit exp_err, push_tx;
    bit [NCH-1:0] ftx, frx;
    int rx_pre [NCH];
    for (int i = 0; i < NCH; i++) begin
      chk("tx_valid", 32'(acc_tx_valid[i]), 32'(tx_m[i].size() != 0));
      if (tx_m[i].size() != 0) chk("tx_data", acc_tx_data[i*DW +: DW], tx_m[i][0]);
      chk("rx_ready", 32'(acc_rx_ready[i]), 32'(rx_m[i].size() < DEP));
      rx_pre[i] = rx_m[i].size();
    end
    exp_err = 0; push_tx = 0; ftx = '0; frx = '0; c = 0;
    if (we) begin
      k = bdec(wa, c);
      if (k == 0) begin
        if (tx_m[c].size() == DEP) exp_err = 1; else push_tx = 1;
      end else if (k == 2) begin
        ftx[c] = wd[0];
        frx[c] = wd[1];
      end else exp_err = 1;
    end
    wr_valid = we; wr_addr = wa; wdata = wd;
    acc_tx_ready = txr; acc_rx_valid = rxv; acc_rx_data = rxd;
    @(posedge clk); #1;
    wr_valid = 0; acc_tx_ready = '0; acc_rx_valid = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ftx[i]) tx_m[i].delete();
      else begin
        if (txr[i] && tx_m[i].size() != 0) void'(tx_m[i].pop_front());
        if (push_tx && i == c) tx_m[i].push_back(wd);
      end
      if (frx[i]) rx_m[i].delete();
      else if (rxv[i] && rx_pre[i] < DEP) rx_m[i].push_back(rxd[i*DW +: DW]);
    end
    chk("wr_err", 32'(wr_err), 32'(exp_err));
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                    output int lat);
    chk("arready", 32'(arready), 32'd1);
    araddr = a; arvalid = 1; rready = 1;
    @(posedge clk); #1;
    arvalid = 0;
    lat = 1;
    while (!rvalid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rvalid", 32'(rvalid), 32'd1);
    d = rdata; r = rresp;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    bit          exp_err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d0;
    logic [1:0]  r;
    int lat, c, k;
    bit stable;
    logic [NCH*DW-1:0] rxd;

    tbl[0] = '{1, 32'h604, 0, 32'h0000_000A, 2'b00, 0};
    tbl[1] = '{1, 32'h614, 0, 32'h0000_000A, 2'b00, 0};
    tbl[2] = '{1, 32'h608, 0, 32'h0,         2'b00, 0};
    tbl[3] = '{1, 32'h60C, 0, 32'hAAAA_AAAA, 2'b11, 0};
    tbl[4] = '{1, 32'h620, 0, 32'hAAAA_AAAA, 2'b11, 0};
    tbl[5] = '{1, 32'h5FC, 0, 32'hAAAA_AAAA, 2'b11, 0};
    tbl[6] = '{1, 32'h602, 0, 32'hAAAA_AAAA, 2'b11, 0};
    tbl[7] = '{0, 32'h604, 32'h55, 0, 2'b00, 1};
    tbl[8] = '{0, 32'h700, 32'h55, 0, 2'b00, 1};
    tbl[9] = '{0, 32'h618, 32'h0,  0, 2'b00, 0};

    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_tx_valid", 32'(acc_tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(acc_rx_ready), 32'd3);
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_rd) begin
        rd(tbl[i].addr, d, r, lat);
        chk("tbl_rdata", d, tbl[i].exp_d);
        chk("tbl_rresp", 32'(r), 32'(tbl[i].exp_r));
        chk("tbl_lat", lat, 1);
      end else begin
        cyc(1, tbl[i].addr, tbl[i].wd, '0, '0, '0);
        chk("tbl_wr_err", 32'(wr_err), 32'(tbl[i].exp_err));
      end
    end

    // TX push and accelerator pop
    cyc(1, 32'h610, 32'h1234_5678, '0, '0, '0);
    chk("t1_valid", 32'(acc_tx_valid[1]), 32'd1);
    chk("t1_data", acc_tx_data[DW +: DW], 32'h1234_5678);
    cyc(0, 0, 0, 2'b10, '0, '0);
    rd(32'h614, d, r, lat);
    chk("t1_status", d, 32'h0000_000A);

    // blocking read satisfied by a late accelerator push
    rxd = '0; rxd[0 +: DW] = 32'hCAFE_0001;
    fork
      rd(32'h600, d, r, lat);
      begin
        repeat (10) begin @(posedge clk); #1; end
        cyc(0, 0, 0, '0, 2'b01, rxd);
      end
    join
    void'(rx_m[0].pop_front());
    chk("t2_data", d, 32'hCAFE_0001);
    chk("t2_resp", 32'(r), 32'd0);
    chk("t2_lat", lat, 14);

    // timeout
    rd(32'h600, d, r, lat);
    chk("t3_data", d, 32'hDEAD_0000);
    chk("t3_resp", 32'(r), 32'd2);
    chk("t3_lat", lat, TMO + 1);

    // fill past full, drain, refill, drain across the pointer wrap
    for (int i = 0; i < 17; i++) begin
      cyc(1, 32'h600, 32'hA000_0000 + i, '0, '0, '0);
      chk("t4_err", 32'(wr_err), 32'(i == 16));
    end
    rd(32'h604, d, r, lat);
    chk("t4_status", d, 32'h0000_1009);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        chk("t4_order", acc_tx_data[0 +: DW], (p == 0 ? 32'hA000_0000 : 32'hB000_0000) + i);
        cyc(0, 0, 0, 2'b01, '0, '0);
      end
      if (p == 0) for (int i = 0; i < 16; i++) cyc(1, 32'h600, 32'hB000_0000 + i, '0, '0, '0);
    end
    chk("t4_empty", 32'(acc_tx_valid[0]), 32'd0);

    // RX flush beats a same-cycle accelerator push; TX flush
    for (int i = 0; i < 5; i++) begin
      rxd = '0; rxd[DW +: DW] = 32'hC500_0000 + i;
      cyc(0, 0, 0, '0, 2'b10, rxd);
    end
    rd(32'h614, d, r, lat);
    chk("t5_pre", d, 32'h0005_0002);
    cyc(1, 32'h618, 32'h2, '0, 2'b10, rxd);
    rd(32'h614, d, r, lat);
    chk("t5_post", d, 32'h0000_000A);
    cyc(1, 32'h600, 32'h11, '0, '0, '0);
    cyc(1, 32'h600, 32'h22, '0, '0, '0);
    cyc(1, 32'h608, 32'h1, '0, '0, '0);
    chk("t5_tx_flush", 32'(acc_tx_valid[0]), 32'd0);

    // response held under rready=0
    rxd = '0; rxd[DW +: DW] = 32'h5151_0001;
    cyc(0, 0, 0, '0, 2'b10, rxd);
    araddr = 32'h610; arvalid = 1; rready = 0;
    @(posedge clk); #1;
    arvalid = 0;
    k = 0;
    while (!rvalid && k < 10) begin @(posedge clk); #1; k++; end
    d0 = rdata;
    stable = 1;
    repeat (20) begin
      @(posedge clk); #1;
      if (rdata !== d0 || rvalid !== 1'b1 || rresp !== 2'b00) stable = 0;
    end
    chk("t6_data", rdata, 32'h5151_0001);
    chk("t6_stable", 32'(stable), 32'd1);
    chk("t6_arready", 32'(arready), 32'd0);
    rready = 1;
    @(posedge clk); #1;
    chk("t6_release", 32'(rvalid), 32'd0);
    void'(rx_m[1].pop_front());

    // reset while blocked in WAIT_DATA
    cyc(1, 32'h600, 32'h77, '0, '0, '0);
    araddr = 32'h600; arvalid = 1;
    @(posedge clk); #1;
    arvalid = 0;
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_rvalid", 32'(rvalid), 32'd0);
    chk("t6_rst_arready", 32'(arready), 32'd1);
    chk("t6_rst_txv", 32'(acc_tx_valid), 32'd0);
    for (int i = 0; i < NCH; i++) begin tx_m[i].delete(); rx_m[i].delete(); end
    #3 rst_n = 1;
    @(posedge clk); #1;
    rd(32'h604, d, r, lat);
    chk("t6_after", d, 32'h0000_000A);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      k = $urandom_range(0, 99);
      c = $urandom_range(0, NCH - 1);
      if (k < 70) begin
        logic [31:0] wa;
        int s;
        s = $urandom_range(0, 19);
        if (s == 16)      wa = BASE + 32'(c * 16) + 32'h4;
        else if (s == 17) wa = ($urandom_range(0, 3) == 0) ? BASE + 32'(c * 16) + 32'h8 : BASE + 32'(c * 16);
        else if (s == 18) wa = BASE + 32'(c * 16) + 32'hC;
        else if (s == 19) wa = 32'h700;
        else              wa = BASE + 32'(c * 16);
        for (int i = 0; i < NCH; i++) rxd[i*DW +: DW] = $urandom;
        cyc($urandom_range(0, 9) < 6, wa, $urandom,
            NCH'({$urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3}),
            NCH'({$urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4}), rxd);
      end else if (k >= 85 && rx_m[c].size() != 0) begin
        rd(BASE + 32'(c * 16), d, r, lat);
        chk("rnd_data", d, rx_m[c].pop_front());
        chk("rnd_data_lat", lat, 3);
      end else begin
        rd(BASE + 32'(c * 16) + 32'h4, d, r, lat);
        chk("rnd_status", d, m_status(c));
        chk("rnd_status_resp", 32'(r), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
